// File: rtl/video_console_pkg.sv
// Shared constants and types for the video text console front end.
package video_console_pkg;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  localparam logic [7:0] CHR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } vc_state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHR_PRINT_LO) && (c <= CHR_PRINT_HI);
  endfunction

endpackage

// File: rtl/video_console_cursor.sv
// Cursor column/row counter with a linear address kept in step without a multiplier.
module video_console_cursor #(
  parameter int unsigned TW  = 80,
  parameter int unsigned TH  = 2,
  parameter int unsigned MAW = 8,
  parameter int unsigned CW  = $clog2(TW),
  parameter int unsigned RW  = $clog2(TH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clk_en,
  input  logic           i_advance,
  input  logic           i_newline,
  input  logic           i_cret,
  input  logic           i_bksp,
  input  logic           i_home,
  output logic [CW-1:0]  o_col,
  output logic [RW-1:0]  o_row,
  output logic [MAW-1:0] o_adr
);

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [MAW-1:0] r_adr;

  logic w_last_col;
  logic w_last_row;

  assign w_last_col = (r_col == CW'(TW - 1));
  assign w_last_row = (r_row == RW'(TH - 1));

  // Commands are mutually exclusive from the FSM; home has priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
      r_adr <= '0;
    end else if (i_clk_en) begin
      if (i_home) begin
        r_col <= '0;
        r_row <= '0;
        r_adr <= '0;
      end else if (i_advance) begin
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row <= '0;
            r_adr <= '0;
          end else begin
            r_row <= r_row + RW'(1);
            r_adr <= r_adr + MAW'(1);
          end
        end else begin
          r_col <= r_col + CW'(1);
          r_adr <= r_adr + MAW'(1);
        end
      end else if (i_newline) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row <= '0;
          r_adr <= '0;
        end else begin
          r_row <= r_row + RW'(1);
          r_adr <= r_adr - MAW'(r_col) + MAW'(TW);
        end
      end else if (i_cret) begin
        r_col <= '0;
        r_adr <= r_adr - MAW'(r_col);
      end else if (i_bksp) begin
        if (r_col != '0) begin
          r_col <= r_col - CW'(1);
          r_adr <= r_adr - MAW'(1);
        end
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;
  assign o_adr = r_adr;

endmodule

// File: rtl/video_console_writer.sv
// Character-stream writer for the text console memory: handshake, control codes, clear sweep.
// Optional feature: VIDEO_CONSOLE_WRITER_CLEAR_ON_RESET_EN (reset starts a full clear sweep).
module video_console_writer
  import video_console_pkg::*;
#(
  parameter int unsigned TW  = 80,
  parameter int unsigned TH  = 2,
  parameter int unsigned MAW = 8,
  parameter int unsigned MDW = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  input  logic                  i_chr_valid,
  input  logic [7:0]            i_chr_dat,
  output logic                  o_chr_ready,
  input  logic                  i_clr,
  output logic                  o_busy,
  output logic [$clog2(TW)-1:0] o_cur_col,
  output logic [$clog2(TH)-1:0] o_cur_row,
  output logic                  o_con_we,
  output logic [MAW-1:0]        o_con_adr_w,
  output logic [MDW-1:0]        o_con_dat_w
);

  localparam int unsigned NCELL = TW * TH;
  localparam int unsigned SCW   = $clog2(NCELL + 1);

  vc_state_e      r_state,  w_state_nxt;
  logic           r_con_we, w_con_we_nxt;
  logic [MAW-1:0] r_con_adr_w, w_con_adr_nxt;
  logic [MDW-1:0] r_con_dat_w, w_con_dat_nxt;
  logic           r_busy,   w_busy_nxt;
  logic [SCW-1:0] r_sweep,  w_sweep_nxt;

  logic           w_xfer;
  logic           w_advance, w_newline, w_cret, w_bksp, w_home;
  logic [MAW-1:0] w_cur_adr;

  assign o_chr_ready = (r_state == ST_IDLE) && !i_clr;
  assign w_xfer      = i_clk_en && i_chr_valid && o_chr_ready;

  video_console_cursor #(
    .TW  (TW),
    .TH  (TH),
    .MAW (MAW)
  ) u_cursor (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clk_en  (i_clk_en),
    .i_advance (w_advance),
    .i_newline (w_newline),
    .i_cret    (w_cret),
    .i_bksp    (w_bksp),
    .i_home    (w_home),
    .o_col     (o_cur_col),
    .o_row     (o_cur_row),
    .o_adr     (w_cur_adr)
  );

  // r_sweep is the next sweep address; reaching NCELL ends the sweep.
  always_comb begin
    w_state_nxt   = r_state;
    w_con_we_nxt  = 1'b0;
    w_con_adr_nxt = r_con_adr_w;
    w_con_dat_nxt = r_con_dat_w;
    w_busy_nxt    = r_busy;
    w_sweep_nxt   = r_sweep;
    w_advance     = 1'b0;
    w_newline     = 1'b0;
    w_cret        = 1'b0;
    w_bksp        = 1'b0;
    w_home        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr || (w_xfer && (i_chr_dat == CHR_FF))) begin
          w_state_nxt   = ST_CLEAR;
          w_con_we_nxt  = 1'b1;
          w_con_adr_nxt = '0;
          w_con_dat_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_sweep_nxt   = SCW'(1);
        end else if (w_xfer) begin
          if (is_printable(i_chr_dat)) begin
            w_con_we_nxt  = 1'b1;
            w_con_adr_nxt = w_cur_adr;
            w_con_dat_nxt = MDW'(i_chr_dat);
            w_advance     = 1'b1;
          end else begin
            case (i_chr_dat)
              CHR_LF:  w_newline = 1'b1;
              CHR_CR:  w_cret    = 1'b1;
              CHR_BS:  w_bksp    = 1'b1;
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (r_sweep == SCW'(NCELL)) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_home      = 1'b1;
        end else begin
          w_con_we_nxt  = 1'b1;
          w_con_adr_nxt = MAW'(r_sweep);
          w_con_dat_nxt = '0;
          w_sweep_nxt   = r_sweep + SCW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
`ifdef VIDEO_CONSOLE_WRITER_CLEAR_ON_RESET_EN
      r_state     <= ST_CLEAR;
      r_con_we    <= 1'b1;
      r_busy      <= 1'b1;
      r_sweep     <= SCW'(1);
`else
      r_state     <= ST_IDLE;
      r_con_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_sweep     <= '0;
`endif
      r_con_adr_w <= '0;
      r_con_dat_w <= '0;
    end else if (i_clk_en) begin
      r_state     <= w_state_nxt;
      r_con_we    <= w_con_we_nxt;
      r_con_adr_w <= w_con_adr_nxt;
      r_con_dat_w <= w_con_dat_nxt;
      r_busy      <= w_busy_nxt;
      r_sweep     <= w_sweep_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_con_we    = r_con_we;
  assign o_con_adr_w = r_con_adr_w;
  assign o_con_dat_w = r_con_dat_w;

endmodule
